// File: rtl/vga_pkg.sv
// Shared types and default widths for the VGA status path.
package vga_pkg;

  localparam int DEST_W_DEF  = 8;
  localparam int STATE_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } status_state_t;

endpackage

// File: rtl/vga_bit_sync.sv
// N-stage single-bit synchronizer into the pixel_clk domain, async reset to 0.
module vga_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/vga_status_sync.sv
// Brings elevator status across to pixel_clk via a 4-phase req/ack handshake and
// commits it only at the vsync falling edge. Optional blink phase: VGA_STATUS_BLINK_EN.
module vga_status_sync
  import vga_pkg::*;
#(
  parameter int DEST_W       = DEST_W_DEF,
  parameter int STATE_W      = STATE_W_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               upd_req,
  input  logic [DEST_W-1:0]  upd_destination,
  input  logic [STATE_W-1:0] upd_sim_state,
  input  logic               vsync,
  output logic               upd_ack,
  output logic [DEST_W-1:0]  destination,
  output logic [STATE_W-1:0] sim_state,
  output logic               pending,
  output logic               blink
);

  if (SYNC_STAGES < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("vga_status_sync: SYNC_STAGES must be >= 2 and BLINK_FRAMES >= 1");
  end

  status_state_t      state;
  status_state_t      state_next;
  logic               req_s;
  logic               vsync_q;
  logic               vs_fall;
  logic               capture;
  logic               commit;
  logic [DEST_W-1:0]  shadow_dest;
  logic [STATE_W-1:0] shadow_state;

  vga_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .d        (upd_req),
    .q        (req_s)
  );

  assign vs_fall = vsync_q & ~vsync;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Data is captured once on entry to PENDING and only released to the display at vsync.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          state_next = PENDING;
          capture    = 1'b1;
        end
      end
      PENDING: begin
        if (vs_fall) begin
          state_next = ACK;
          commit     = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      shadow_dest  <= '0;
      shadow_state <= '0;
      destination  <= '0;
      sim_state    <= '0;
      pending      <= 1'b0;
      upd_ack      <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (capture) begin
        shadow_dest  <= upd_destination;
        shadow_state <= upd_sim_state;
      end
      if (commit) begin
        destination <= shadow_dest;
        sim_state   <= shadow_state;
      end
      pending <= (state_next == PENDING);
      upd_ack <= (state_next == ACK);
    end
  end

`ifdef VGA_STATUS_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_q;

  // Blink half-period counted in whole frames so the phase flips only between frames.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (vs_fall) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_status_sync.sv
// Self-checking bench for vga_status_sync: directed handshake cases plus randomized
// transactions, compared every cycle against a transaction-level model.
module tb_vga_status_sync;

  localparam int SYNC   = 2;
  localparam int BF     = 3;
  localparam int FRAME  = 24;
  localparam int VS_LEN = 3;
  localparam int F      = FRAME - VS_LEN;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       upd_req = 1'b0;
  logic       vsync = 1'b1;
  logic [7:0] upd_destination = 8'h00;
  logic [1:0] upd_sim_state = 2'b00;
  logic       upd_ack;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic       pending;
  logic       blink;

  int checks = 0;
  int passes = 0;
  int frame_pos = 0;

  logic [SYNC-1:0] m_hist;
  logic            m_prev_vs;
  logic            m_wait;
  logic            m_ack;
  logic [7:0]      m_sh_dest;
  logic [7:0]      m_dest;
  logic [1:0]      m_sh_state;
  logic [1:0]      m_state;
  int              m_falls;
  logic            m_rs;
  logic            m_fall;
  logic            m_blink;

  always #5 pixel_clk = ~pixel_clk;

  vga_status_sync #(
    .DEST_W      (8),
    .STATE_W     (2),
    .SYNC_STAGES (SYNC),
    .BLINK_FRAMES(BF)
  ) dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .upd_req        (upd_req),
    .upd_destination(upd_destination),
    .upd_sim_state  (upd_sim_state),
    .vsync          (vsync),
    .upd_ack        (upd_ack),
    .destination    (destination),
    .sim_state      (sim_state),
    .pending        (pending),
    .blink          (blink)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the handshake seen as "data waiting" / "acknowledged" flags; req is seen SYNC edges late.
  always @(posedge pixel_clk) begin
    if (reset) begin
      m_hist = '0; m_prev_vs = 1'b1; m_wait = 1'b0; m_ack = 1'b0;
      m_sh_dest = '0; m_sh_state = '0; m_dest = '0; m_state = '0; m_falls = 0;
    end else begin
      m_rs   = m_hist[SYNC-1];
      m_fall = m_prev_vs && !vsync;
      if (m_fall) m_falls++;
      if (m_ack) begin
        if (!m_rs) m_ack = 1'b0;
      end else if (m_wait) begin
        if (m_fall) begin
          m_dest = m_sh_dest; m_state = m_sh_state; m_wait = 1'b0; m_ack = 1'b1;
        end
      end else if (m_rs) begin
        m_sh_dest = upd_destination; m_sh_state = upd_sim_state; m_wait = 1'b1;
      end
      m_hist    = {m_hist[SYNC-2:0], upd_req};
      m_prev_vs = vsync;
    end
`ifdef VGA_STATUS_BLINK_EN
    m_blink = ((m_falls / BF) % 2) == 1;
`else
    m_blink = 1'b0;
`endif
    #1;
    checkOutput("destination", 32'(destination), 32'(m_dest));
    checkOutput("sim_state", 32'(sim_state), 32'(m_state));
    checkOutput("upd_ack", 32'(upd_ack), 32'(m_ack));
    checkOutput("pending", 32'(pending), 32'(m_wait));
    checkOutput("blink", 32'(blink), 32'(m_blink));
  end

  task automatic tick();
    @(negedge pixel_clk);
    frame_pos = (frame_pos + 1) % FRAME;
    vsync = (frame_pos < F);
  endtask

  task automatic tickUntil(input int p);
    do tick(); while (frame_pos != p);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s);
    upd_destination = d;
    upd_sim_state   = s;
    upd_req         = 1'b1;
  endtask

  task automatic waitAck(input logic lvl, input int limit, input string name);
    int n = 0;
    while (upd_ack !== lvl && n < limit) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(upd_ack), 32'(lvl));
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset_dest", 32'(destination), 32'h0);
    checkOutput("reset_state", 32'(sim_state), 32'h0);
    checkOutput("reset_ack", 32'(upd_ack), 32'h0);
    checkOutput("reset_pending", 32'(pending), 32'h0);

    // Idle frames: nothing moves; third fall flips blink when enabled.
    tickUntil(F); tick();
    tickUntil(F); tick();
    checkOutput("idle_dest", 32'(destination), 32'h0);
    tickUntil(F); tick();
`ifdef VGA_STATUS_BLINK_EN
    checkOutput("blink_third_fall", 32'(blink), 32'h1);
`else
    checkOutput("blink_tied_low", 32'(blink), 32'h0);
`endif

    // Mid-frame request; source data changes after capture.
    tickUntil(5);
    applyStimulus(8'hA5, 2'b10);
    tick(); tick();
    checkOutput("pending_early", 32'(pending), 32'h0);
    tick();
    checkOutput("pending_latency", 32'(pending), 32'h1);
    checkOutput("dest_before_vsync", 32'(destination), 32'h0);
    tickUntil(10);
    upd_destination = 8'hFF;
    tickUntil(F);
    checkOutput("ack_before_vsync", 32'(upd_ack), 32'h0);
    tick();
    checkOutput("commit_dest", 32'(destination), 32'hA5);
    checkOutput("commit_state", 32'(sim_state), 32'h2);
    checkOutput("commit_ack", 32'(upd_ack), 32'h1);
    checkOutput("commit_pending", 32'(pending), 32'h0);
    upd_req = 1'b0;
    waitAck(1'b0, 8, "ack_release");

    // Synchronized request lands on the same edge as vs_fall: capture only.
    tickUntil(F - SYNC);
    applyStimulus(8'h3C, 2'b01);
    tickUntil(F + 1);
    checkOutput("coinc_pending", 32'(pending), 32'h1);
    checkOutput("coinc_no_commit", 32'(destination), 32'hA5);
    tickUntil(F);
    checkOutput("coinc_hold", 32'(destination), 32'hA5);
    tick();
    checkOutput("coinc_commit_dest", 32'(destination), 32'h3C);
    checkOutput("coinc_commit_state", 32'(sim_state), 32'h1);
    upd_req = 1'b0;
    waitAck(1'b0, 8, "coinc_ack_release");

    // Request withdrawn while pending: commit anyway, one-cycle ack.
    tickUntil(2);
    applyStimulus(8'hC3, 2'b11);
    repeat (4) tick();
    checkOutput("viol_pending", 32'(pending), 32'h1);
    upd_req = 1'b0;
    tickUntil(F);
    tick();
    checkOutput("viol_commit", 32'(destination), 32'hC3);
    checkOutput("viol_ack_pulse", 32'(upd_ack), 32'h1);
    tick();
    checkOutput("viol_ack_drop", 32'(upd_ack), 32'h0);

    // Reset during pending aborts; handshake restarts afterwards.
    tickUntil(2);
    applyStimulus(8'h5A, 2'b11);
    repeat (4) tick();
    checkOutput("rst_pre_pending", 32'(pending), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_dest", 32'(destination), 32'h0);
    checkOutput("rst_state", 32'(sim_state), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
    checkOutput("rst_ack", 32'(upd_ack), 32'h0);
    tick();
    reset = 1'b0;
    tickUntil(F);
    checkOutput("rst_no_commit_yet", 32'(destination), 32'h0);
    tick();
    checkOutput("rst_restart_dest", 32'(destination), 32'h5A);
    checkOutput("rst_restart_ack", 32'(upd_ack), 32'h1);
    upd_req = 1'b0;
    waitAck(1'b0, 8, "rst_ack_release");

    // Randomized protocol-compliant transactions.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) tick();
      applyStimulus(8'($urandom), 2'($urandom));
      waitAck(1'b1, 3 * FRAME, "rand_ack_rise");
      repeat ($urandom_range(0, 5)) tick();
      upd_req = 1'b0;
      waitAck(1'b0, 8, "rand_ack_fall");
    end

    repeat (3) tick();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
